// File: rtl/fifo_reader.sv
// fifo_reader: drains syn_fifo into a valid/ready stream, 2-cycle ren-to-valid, 1 beat/cycle; m_ready low stalls ren after 2 words.
// Optional FIFO_READER_SEQCHK_EN adds an incrementing-sequence checker driving the sticky seq_err flag.
module fifo_reader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_ren,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [WIDTH-1:0] beat_cnt,
  output logic             seq_err
);

  logic [WIDTH-1:0] buf_mem [2];
  logic             wptr;
  logic             rptr;
  logic             ren_q;
  logic [1:0]       occ;
  logic             pop;
  logic [2:0]       committed;
  logic [2:0]       limit;

  assign pop     = m_valid & m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_mem[rptr];

  // Words held plus the one in flight must leave room; a pop this cycle frees a slot immediately.
  assign committed = {1'b0, occ} + {2'b00, ren_q};
  assign limit     = 3'd2 + {2'b00, pop};
  assign fifo_ren  = rst_n & ~fifo_empty & (committed < limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      ren_q      <= 1'b0;
      occ        <= 2'd0;
      beat_cnt   <= '0;
    end else begin
      ren_q <= fifo_ren;
      if (ren_q) begin
        buf_mem[wptr] <= fifo_data;
        wptr          <= ~wptr;
      end
      if (pop) begin
        rptr     <= ~rptr;
        beat_cnt <= beat_cnt + 1'b1;
      end
      case ({ren_q, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_READER_SEQCHK_EN
  logic [WIDTH-1:0] exp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_cnt <= '0;
      seq_err <= 1'b0;
    end else if (pop) begin
      exp_cnt <= exp_cnt + 1'b1;
      if (m_data != exp_cnt) begin
        seq_err <= 1'b1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  // A capture into a full buffer would mean the issue rule leaked a credit.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    ren_q |-> ((occ != 2'd2) || pop));

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side drain engine for the `syn_fifo` synchronous FIFO. It issues `ren` pulses against the FIFO's `empty` flag and absorbs the FIFO's one-cycle registered read latency. It re-presents the data as a valid/ready stream for downstream consumers, using a 2-entry output buffer so it sustains one beat per cycle under continuous `m_ready`. It sits directly on the FIFO read port and is the consumer counterpart of the FIFO write-side logic.

## Interface
- `WIDTH`, 16, data width; must match the FIFO `WIDTH`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`; valid in the cycle after `fifo_ren` was high.
- `fifo_ren`  out  1  read enable to the FIFO; combinational.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH  output beat data.
- `beat_cnt`  out  WIDTH  count of accepted beats (`m_valid & m_ready`); wraps modulo 2^WIDTH.
- `seq_err`  out  1  sticky sequence-error flag (see Configuration).

## Operation
- Internal state:
  - 2-entry buffer `buf[0..1]` with read and write pointers.
  - occupancy `occ` (0..2).
  - `ren_q`, the registered `fifo_ren`, which marks a read in flight.
- `pop = m_valid & m_ready`.
- Issue rule: `fifo_ren = !fifo_empty & (occ + ren_q - pop < 2)`.
  - `fifo_ren` is never high while `fifo_empty` is high.
  - The buffer can never overflow.
- Capture: when `ren_q` is high, `fifo_data` is written into `buf[wptr]` at that edge and `wptr` toggles.
- Output:
  - `m_valid = (occ != 0)`.
  - `m_data = buf[rptr]`.
  - On `pop`, `rptr` toggles.
- Occupancy update, all cases:
  - capture only: `occ` +1.
  - pop only: `occ` -1.
  - capture and pop in the same cycle: `occ` unchanged.
- `m_data` is held stable while `m_valid & !m_ready`.
- `beat_cnt` increments by 1 on each `pop` and wraps from all-ones to 0.
- Reset while `rst_n` is low:
  - `occ`, `ren_q`, pointers and `beat_cnt` are 0.
  - `m_valid` is 0, `seq_err` is 0 and `m_data` is 0.
  - `fifo_ren` is forced 0.
  - A read in flight at reset assertion is discarded. That word is lost from the stream; this is the intended behaviour.

## Timing
- `fifo_ren` is high in cycle N; `fifo_data` is valid in N+1 and captured at the end of N+1; `m_valid` rises in N+2.
- Read-to-output latency is 2 cycles.
- First-word latency from `fifo_empty` deasserting (cycle N, buffer empty) to `m_valid`: 2 cycles.
- Throughput: 1 beat/cycle with `m_ready` held high and the FIFO non-empty.
- With `m_ready` low, at most 2 words are drained, then `fifo_ren` stays low.
- After `m_ready` rises again, `fifo_ren` reasserts in the same cycle as the first `pop` (credit-on-pop).
- Critical path: `fifo_ren` is combinational from `fifo_empty`, `m_ready`, `occ` and `ren_q`.
- Reset deassertion: the first possible `fifo_ren` is in the first cycle with `rst_n` high.

## Configuration
- Macro: `FIFO_READER_SEQCHK_EN`.
- Defined:
  - An expected-value counter `exp` (WIDTH bits) resets to 0 and increments on each `pop`.
  - If `pop & (m_data != exp)`, `seq_err` sets on the next edge and stays set until reset.
  - The check assumes the writer sends an incrementing pattern starting at 0.
- Undefined: `seq_err` is tied to 0 and the `exp` counter is not present.

## Test plan
- **Reset:** hold `rst_n` low with `fifo_empty`=0 → `fifo_ren`=0, `m_valid`=0, `beat_cnt`=0, `seq_err`=0.
- **Single word:** FIFO holds 0x0000, `m_ready`=1 → `fifo_ren` high for 1 cycle, `m_valid` high 2 cycles later with `m_data`=0x0000, `beat_cnt`=1.
- **Streaming:** FIFO preloaded with 0..7, `m_ready`=1 → 8 consecutive beats with `m_data` 0..7, no bubbles after the first, `beat_cnt`=8, `fifo_ren` never high while `fifo_empty`=1.
- **Backpressure:** `m_ready`=0 for 10 cycles with 8 words queued → exactly 2 `fifo_ren` pulses, `m_data`=0 held stable; then `m_ready`=1 → remaining words 1..7 delivered in order, none lost or duplicated.
- **Random load:** random `m_ready`, random FIFO writes of an incrementing pattern for 10k cycles → with `FIFO_READER_SEQCHK_EN` defined, `seq_err`=0; a corrupted word injected on write → `seq_err`=1 one cycle after that beat is accepted, and it stays 1.
- **Reset mid-flight:** assert `rst_n`=0 in the cycle after a `fifo_ren` → `m_valid`=0 immediately and the in-flight word is not presented after release.
